// File: rtl/light_pkg.sv
// Shared types for the traffic-light output monitor.
// Light codes, error codes, checker states and limit helpers.
package light_pkg;

    typedef enum logic [1:0] {
        L_OFF    = 2'd0,
        L_RED    = 2'd1,
        L_GREEN  = 2'd2,
        L_YELLOW = 2'd3
    } light_t;

    typedef enum logic [2:0] {
        E_NONE  = 3'd0,
        E_TRANS = 3'd1,
        E_SHORT = 3'd2,
        E_LONG  = 3'd3,
        E_STATE = 3'd4
    } err_t;

    typedef enum logic {
        S_SYNC  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    // Clamp a signed tick limit into the 9-bit compare range.
    function automatic logic [8:0] lim(input int v);
        logic [8:0] r;
        if (v < 0) begin
            r = 9'd0;
        end else if (v > 511) begin
            r = 9'h1FF;
        end else begin
            r = v[8:0];
        end
        return r;
    endfunction

    // Normal cycle order: RED -> GREEN -> YELLOW -> RED.
    function automatic logic legal_normal(input light_t f, input light_t t);
        logic ok;
        ok = ((f == L_RED) && (t == L_GREEN)) ||
             ((f == L_GREEN) && (t == L_YELLOW)) ||
             ((f == L_YELLOW) && (t == L_RED));
        return ok;
    endfunction

    // Flashing only toggles between OFF and YELLOW.
    function automatic logic legal_flash(input light_t f, input light_t t);
        logic ok;
        ok = ((f == L_OFF) && (t == L_YELLOW)) ||
             ((f == L_YELLOW) && (t == L_OFF));
        return ok;
    endfunction

endpackage

// File: rtl/light_monitor_edge_sync.sv
// Multi-stage synchronizer with registered rising-edge pulse.
// Used to turn an asynchronous beat into a one-cycle tick.
module edge_sync #(
    parameter int C_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);

    logic [C_STAGES-1:0] r_sync;
    logic                r_prev;
    logic                r_pulse;

    // Shift the async input through the sync chain and flag rising edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[C_STAGES-2:0], i_async};
            r_prev  <= r_sync[C_STAGES-1];
            r_pulse <= r_sync[C_STAGES-1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/light_monitor.sv
// Passive observer of the traffic-light outputs.
// Checks phase order and durations, latches the first violation.
module light_monitor
    import light_pkg::*;
#(
    parameter int C_INT_RED        = 15,
    parameter int C_INT_GREEN      = 20,
    parameter int C_INT_YELLOW     = 5,
    parameter int C_INT_PEDESTRIAN = 10,
    parameter int C_TOL            = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blink,
    input  logic       inMode,
    input  logic [1:0] inLight,
    output logic [1:0] outState,
    output logic [7:0] outCount,
    output logic       outPhaseDone,
    output logic       outErr,
    output logic [2:0] outErrCode
);

    localparam logic [8:0] LP_RED_LO = lim(C_INT_RED - C_TOL);
    localparam logic [8:0] LP_RED_HI = lim(C_INT_RED + C_TOL);
    localparam logic [8:0] LP_GRN_LO = lim(C_INT_PEDESTRIAN - C_TOL);
    localparam logic [8:0] LP_GRN_HI = lim(C_INT_GREEN + C_TOL);
    localparam logic [8:0] LP_YEL_LO = lim(C_INT_YELLOW - C_TOL);
    localparam logic [8:0] LP_YEL_HI = lim(C_INT_YELLOW + C_TOL);

    logic       w_tick;
    light_t     r_light_q;
    light_t     r_light_d;
    logic       r_mode_q;
    logic       r_mode_d;
    logic [1:0] r_valid;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_inc;
    logic       w_change;
    logic       w_mode_chg;
    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_done;
    logic       w_err_set;
    err_t       w_err_code;
    logic [7:0] r_count;
    logic       r_done;
    logic       r_err;
    err_t       r_code;

    function automatic logic [8:0] f_lo(input light_t l);
        logic [8:0] v;
        case (l)
            L_RED:    v = LP_RED_LO;
            L_GREEN:  v = LP_GRN_LO;
            L_YELLOW: v = LP_YEL_LO;
            default:  v = 9'd0;
        endcase
        return v;
    endfunction

    function automatic logic [8:0] f_hi(input light_t l);
        logic [8:0] v;
        case (l)
            L_RED:    v = LP_RED_HI;
            L_GREEN:  v = LP_GRN_HI;
            L_YELLOW: v = LP_YEL_HI;
            default:  v = 9'h1FF;
        endcase
        return v;
    endfunction

    // Illegal state beats illegal transition, which beats duration.
    function automatic err_t f_check(
        input light_t     f,
        input light_t     t,
        input logic       flash,
        input logic [7:0] d
    );
        err_t e;
        e = E_NONE;
        if (!flash) begin
            if (t == L_OFF) begin
                e = E_STATE;
            end else if (!legal_normal(f, t)) begin
                e = E_TRANS;
            end else if ({1'b0, d} < f_lo(f)) begin
                e = E_SHORT;
            end else if ({1'b0, d} > f_hi(f)) begin
                e = E_LONG;
            end
        end else begin
            if ((t == L_RED) || (t == L_GREEN)) begin
                e = E_STATE;
            end else if (!legal_flash(f, t)) begin
                e = E_TRANS;
            end
        end
        return e;
    endfunction

    edge_sync #(
        .C_STAGES(2)
    ) u_blink_sync (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_async(blink),
        .o_pulse(w_tick)
    );

    // The valid pipe masks the fake change right after reset.
    assign w_change   = r_valid[1] && (r_light_q != r_light_d);
    assign w_mode_chg = r_valid[1] && (r_mode_q != r_mode_d);
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;

    // Input registers plus one-cycle history for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_light_q <= L_OFF;
            r_light_d <= L_OFF;
            r_mode_q  <= 1'b0;
            r_mode_d  <= 1'b0;
            r_valid   <= 2'b00;
        end else begin
            r_light_q <= light_t'(inLight);
            r_light_d <= r_light_q;
            r_mode_q  <= inMode;
            r_mode_d  <= r_mode_q;
            r_valid   <= {r_valid[0], 1'b1};
        end
    end

    // Saturating phase tick counter; a tick on the change cycle starts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_change) begin
            r_cnt <= w_tick ? 8'd1 : 8'd0;
        end else if (w_tick) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Checker state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, phase completion and error detection.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_err_set   = 1'b0;
        w_err_code  = E_NONE;
        case (r_state)
            S_SYNC: begin
                if (w_mode_chg) begin
                    w_state_nxt = S_SYNC;
                end else if (w_change) begin
                    w_state_nxt = S_TRACK;
                end
            end
            S_TRACK: begin
                if (w_mode_chg) begin
                    w_state_nxt = S_SYNC;
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase
        if ((r_state == S_TRACK) && !w_mode_chg) begin
            if (w_change) begin
                w_done     = 1'b1;
                w_err_code = f_check(r_light_d, r_light_q, r_mode_q, r_cnt);
                w_err_set  = (w_err_code != E_NONE);
            end else if (!r_mode_q && w_tick &&
                         ({1'b0, w_cnt_inc} > f_hi(r_light_q))) begin
                w_err_code = E_LONG;
                w_err_set  = 1'b1;
            end
        end
    end

    // Completed-phase duration and pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_done) begin
                r_count <= r_cnt;
            end
        end
    end

    // Sticky first-error latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_code <= E_NONE;
        end else if (!r_err && w_err_set) begin
            r_err  <= 1'b1;
            r_code <= w_err_code;
        end
    end

    assign outState     = r_light_q;
    assign outCount     = r_count;
    assign outPhaseDone = r_done;
    assign outErr       = r_err;
    assign outErrCode   = r_code;

endmodule

// File: tb/tb_light_monitor.sv
// Directed bench for light_monitor.
// Each task drives one scenario and compares outputs inline.
module tb_light_monitor;

    logic       clk;
    logic       rst;
    logic       blink;
    logic       inMode;
    logic [1:0] inLight;
    logic [1:0] outState;
    logic [7:0] outCount;
    logic       outPhaseDone;
    logic       outErr;
    logic [2:0] outErrCode;

    int n_cmp;
    int n_bad;
    int p_seen;
    int p_cnt;

    localparam logic [1:0] OFF = 2'd0;
    localparam logic [1:0] RED = 2'd1;
    localparam logic [1:0] GRN = 2'd2;
    localparam logic [1:0] YEL = 2'd3;

    light_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .blink       (blink),
        .inMode      (inMode),
        .inLight     (inLight),
        .outState    (outState),
        .outCount    (outCount),
        .outPhaseDone(outPhaseDone),
        .outErr      (outErr),
        .outErrCode  (outErrCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset(input logic [1:0] l, input logic m);
        @(negedge clk);
        inLight = l;
        inMode  = m;
        blink   = 1'b0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            blink = 1'b1;
            repeat (4) @(negedge clk);
            blink = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic phase(input logic [1:0] l);
        p_seen  = 0;
        p_cnt   = 0;
        inLight = l;
        repeat (4) begin
            @(negedge clk);
            if (outPhaseDone) begin
                p_seen++;
                p_cnt = int'(outCount);
            end
        end
    endtask

    task automatic test_reset;
        do_reset(OFF, 1'b0);
        n_cmp++;
        if (outState !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_state: got %0d want 0", outState);
        end
        n_cmp++;
        if (outCount !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_count: got %0d want 0", outCount);
        end
        n_cmp++;
        if (outPhaseDone !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_done: got %0b want 0", outPhaseDone);
        end
        n_cmp++;
        if ({outErr, outErrCode} !== 4'd0) begin
            n_bad++;
            $display("FAIL rst_err: got %0b/%0d want 0/0", outErr, outErrCode);
        end
    endtask

    task automatic test_normal_cycle;
        do_reset(RED, 1'b0);
        ticks(3);
        phase(GRN);
        n_cmp++;
        if (p_seen !== 0) begin
            n_bad++;
            $display("FAIL sync_no_pulse: got %0d pulses want 0", p_seen);
        end
        n_cmp++;
        if (outState !== GRN) begin
            n_bad++;
            $display("FAIL state_follow: got %0d want 2", outState);
        end
        ticks(20);
        for (int r = 0; r < 3; r++) begin
            phase(YEL);
            n_cmp++;
            if (p_seen !== 1 || p_cnt !== 20) begin
                n_bad++;
                $display("FAIL green_len r%0d: got %0d/%0d want 1/20", r, p_seen, p_cnt);
            end
            ticks(5);
            phase(RED);
            n_cmp++;
            if (p_seen !== 1 || p_cnt !== 5) begin
                n_bad++;
                $display("FAIL yellow_len r%0d: got %0d/%0d want 1/5", r, p_seen, p_cnt);
            end
            ticks(15);
            phase(GRN);
            n_cmp++;
            if (p_seen !== 1 || p_cnt !== 15) begin
                n_bad++;
                $display("FAIL red_len r%0d: got %0d/%0d want 1/15", r, p_seen, p_cnt);
            end
            ticks(20);
        end
        n_cmp++;
        if (outErr !== 1'b0) begin
            n_bad++;
            $display("FAIL normal_err: got %0b want 0", outErr);
        end
    endtask

    task automatic test_pedestrian;
        phase(YEL);
        ticks(5);
        phase(RED);
        ticks(15);
        phase(GRN);
        ticks(9);
        phase(YEL);
        n_cmp++;
        if (outErr !== 1'b0 || p_cnt !== 9) begin
            n_bad++;
            $display("FAIL ped9: got err %0b cnt %0d want 0/9", outErr, p_cnt);
        end
        ticks(5);
        phase(RED);
        ticks(15);
        phase(GRN);
        ticks(8);
        n_cmp++;
        if (outErr !== 1'b0) begin
            n_bad++;
            $display("FAIL ped8_early: got %0b want 0", outErr);
        end
        phase(YEL);
        n_cmp++;
        if (outErr !== 1'b1 || outErrCode !== 3'd2) begin
            n_bad++;
            $display("FAIL ped8_short: got %0b/%0d want 1/2", outErr, outErrCode);
        end
    endtask

    task automatic test_illegal_transition;
        do_reset(RED, 1'b0);
        ticks(3);
        phase(GRN);
        ticks(20);
        phase(RED);
        n_cmp++;
        if (outErr !== 1'b1 || outErrCode !== 3'd1) begin
            n_bad++;
            $display("FAIL grn_to_red: got %0b/%0d want 1/1", outErr, outErrCode);
        end
        ticks(2);
        phase(GRN);
        ticks(20);
        phase(YEL);
        ticks(9);
        phase(RED);
        n_cmp++;
        if (outErrCode !== 3'd1 || p_cnt !== 9) begin
            n_bad++;
            $display("FAIL err_sticky: got code %0d cnt %0d want 1/9", outErrCode, p_cnt);
        end
    endtask

    task automatic test_stuck;
        do_reset(GRN, 1'b0);
        ticks(3);
        phase(YEL);
        ticks(5);
        phase(RED);
        ticks(16);
        n_cmp++;
        if (outErr !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_early: got %0b want 0", outErr);
        end
        blink = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outErr !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_on_tick: got %0b want 0", outErr);
        end
        @(negedge clk);
        n_cmp++;
        if (outErr !== 1'b1 || outErrCode !== 3'd3 || outState !== RED) begin
            n_bad++;
            $display("FAIL stuck_long: got %0b/%0d st %0d want 1/3/1",
                     outErr, outErrCode, outState);
        end
        blink = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_flash;
        int pulses;
        do_reset(RED, 1'b0);
        ticks(2);
        inMode = 1'b1;
        phase(YEL);
        n_cmp++;
        if (p_seen !== 0) begin
            n_bad++;
            $display("FAIL flash_sync: got %0d pulses want 0", p_seen);
        end
        ticks(1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            phase((i % 2 == 0) ? OFF : YEL);
            pulses += p_seen;
            if (p_seen == 1) begin
                n_cmp++;
                if (p_cnt !== 1) begin
                    n_bad++;
                    $display("FAIL flash_len i%0d: got %0d want 1", i, p_cnt);
                end
            end
            ticks(1);
        end
        n_cmp++;
        if (pulses !== 5 || outErr !== 1'b0) begin
            n_bad++;
            $display("FAIL flash_ok: got %0d pulses err %0b want 5/0", pulses, outErr);
        end
        phase(RED);
        n_cmp++;
        if (outErr !== 1'b1 || outErrCode !== 3'd4) begin
            n_bad++;
            $display("FAIL flash_red: got %0b/%0d want 1/4", outErr, outErrCode);
        end
    endtask

    task automatic test_mode_switch;
        do_reset(RED, 1'b0);
        ticks(3);
        phase(GRN);
        ticks(20);
        phase(YEL);
        ticks(2);
        inMode = 1'b1;
        repeat (4) @(negedge clk);
        ticks(1);
        phase(OFF);
        n_cmp++;
        if (p_seen !== 0 || outErr !== 1'b0) begin
            n_bad++;
            $display("FAIL to_flash: got %0d pulses err %0b want 0/0", p_seen, outErr);
        end
        ticks(1);
        inMode = 1'b0;
        repeat (4) @(negedge clk);
        phase(RED);
        n_cmp++;
        if (p_seen !== 0 || outErr !== 1'b0) begin
            n_bad++;
            $display("FAIL to_normal: got %0d pulses err %0b want 0/0", p_seen, outErr);
        end
    endtask

    task automatic test_reset_mid;
        do_reset(RED, 1'b0);
        ticks(2);
        phase(GRN);
        ticks(20);
        phase(RED);
        ticks(2);
        phase(GRN);
        ticks(3);
        n_cmp++;
        if (outErr !== 1'b1 || outCount !== 8'd2) begin
            n_bad++;
            $display("FAIL pre_rst: got err %0b cnt %0d want 1/2", outErr, outCount);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({outState, outCount, outPhaseDone, outErr, outErrCode} !== 15'd0) begin
            n_bad++;
            $display("FAIL mid_rst: got st %0d cnt %0d pd %0b err %0b/%0d want all 0",
                     outState, outCount, outPhaseDone, outErr, outErrCode);
        end
        rst = 1'b0;
        ticks(5);
        phase(YEL);
        n_cmp++;
        if (p_seen !== 0 || outErr !== 1'b0) begin
            n_bad++;
            $display("FAIL partial: got %0d pulses err %0b want 0/0", p_seen, outErr);
        end
        ticks(5);
        phase(RED);
        n_cmp++;
        if (p_seen !== 1 || p_cnt !== 5 || outErr !== 1'b0) begin
            n_bad++;
            $display("FAIL post_rst: got %0d/%0d err %0b want 1/5/0", p_seen, p_cnt, outErr);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        blink   = 1'b0;
        inMode  = 1'b0;
        inLight = OFF;
        test_reset();
        test_normal_cycle();
        test_pedestrian();
        test_illegal_transition();
        test_stuck();
        test_flash();
        test_mode_switch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
# light_monitor

Passive checker on the traffic-light output interface. It consumes the 2-bit light code and the blink beat that the `control` block uses. It confirms that the phase sequence and phase durations match the programmed intervals, and latches the first violation. It sits beside `control` in the top level and in benches, drives nothing back into the controller, and is used as a self-checking observer.

## Interface
Parameters:
- `C_INT_RED`, 15, required RED duration in blink ticks
- `C_INT_GREEN`, 20, maximum GREEN duration in ticks
- `C_INT_YELLOW`, 5, required YELLOW duration in ticks
- `C_INT_PEDESTRIAN`, 10, minimum GREEN duration in ticks (pedestrian-shortened phase)
- `C_TOL`, 1, allowed ± deviation in ticks on every duration check

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `blink` in 1: blink beat, asynchronous to `clk`; each rising edge is one tick
- `inMode` in 1: 0 = normal cycle, 1 = flashing mode
- `inLight` in 2: observed light code (0 OFF, 1 RED, 2 GREEN, 3 YELLOW)
- `outState` out 2: registered copy of the current light
- `outCount` out 8: duration in ticks of the last completed phase
- `outPhaseDone` out 1: one-cycle pulse when a phase completes
- `outErr` out 1: sticky error flag
- `outErrCode` out 3: code of the first error (0 none, 1 illegal transition, 2 too short, 3 too long, 4 illegal state)

## Operation
- `blink` passes through a 2-FF synchronizer followed by a rising-edge detector, which produces `tick`.
- `inLight` and `inMode` are registered once (`light_q`, `mode_q`). A phase change is `inLight != light_q`.
- A running counter `cnt` (8 bit, saturates at 255) increments on each `tick` and clears on a phase change.
- FSM states:
  - SYNC: entered from reset and from any `mode_q` change. No checks are done, because the first phase is partial. On the first phase change it goes to TRACK; `outCount` is not updated and there is no pulse.
  - TRACK: every check is active.
- Normal mode (`mode_q`=0):
  - Legal transitions are RED→GREEN, GREEN→YELLOW and YELLOW→RED. Any other change is code 1.
  - OFF is code 4.
- Flash mode: only OFF↔YELLOW is legal. RED or GREEN is code 4. Durations are not checked.
- Duration check at a phase change in TRACK, using completed duration `d = cnt`:
  - RED: `d` must be in [`C_INT_RED`−`C_TOL`, `C_INT_RED`+`C_TOL`].
  - GREEN: `d` must be in [`C_INT_PEDESTRIAN`−`C_TOL`, `C_INT_GREEN`+`C_TOL`].
  - YELLOW: `d` must be in [`C_INT_YELLOW`−`C_TOL`, `C_INT_YELLOW`+`C_TOL`].
  - Below the range is code 2, above is code 3.
- Stuck detection: in TRACK, normal mode, when `cnt` reaches the upper limit+1 for the current light, raise code 3 immediately and do not wait for the transition.
- Error latching: only the first error is latched. `outErr`/`outErrCode` hold until `rst`. Tracking, `outState`, `outCount` and `outPhaseDone` continue after an error.
- Simultaneous events:
  - Illegal transition with a bad duration: report code 1.
  - Phase change and `tick` in the same cycle: `outCount` gets the old `cnt`, and the new `cnt` becomes 1.
  - Mode change and phase change in the same cycle: enter SYNC and run no check.

## Timing
- Reset values: `outState`=0, `outCount`=0, `outPhaseDone`=0, `outErr`=0, `outErrCode`=0; FSM in SYNC; `cnt`=0.
- `rst` mid-phase clears everything in the next cycle and returns to SYNC.
- `tick` is asserted 3 `clk` cycles after the `blink` rising edge and lasts 1 cycle.
- `outState` follows `inLight` with 1-cycle latency.
- `outPhaseDone`, `outCount`, `outErr` and `outErrCode` update on the cycle after `light_q` changes (2 cycles after `inLight` changes).
- The stuck error asserts 1 cycle after the offending `tick`.

## Structure
- Package `light_pkg`:
  - `light_t` enum (OFF/RED/GREEN/YELLOW)
  - `err_t` enum (codes 0–4)
  - `state_t` (SYNC/TRACK)
- Sub-module `edge_sync`: 2-FF synchronizer plus rising-edge pulse, parameterized by stage count. Reusable for the pedestrian and traffic inputs.

## Test plan
- Legal normal cycle: RED 15, GREEN 20, YELLOW 5 ticks, repeated 3×. Required: `outErr`=0; `outPhaseDone` pulses with `outCount` = 15/20/5.
- Pedestrian-shortened GREEN of 9 ticks: no error. GREEN of 8 ticks: `outErr`=1, `outErrCode`=2 at the change to YELLOW.
- GREEN→RED direct: `outErrCode`=1. A later YELLOW of 9 ticks leaves the code at 1.
- RED held: code 3 asserted 1 cycle after tick 17, before any transition.
- Flash mode:
  - Switch to `inMode`=1, then OFF/YELLOW alternating every tick: no error.
  - Inject RED: code 4.
  - Switch mode mid-phase: first phase after the switch is unchecked.
- `rst` asserted mid-GREEN with an error latched: all outputs 0 next cycle. A partial first phase after reset is not flagged.
